// File: rtl/prog_clk_divider.sv
// prog_clk_divider
//   Runtime-programmable clock-enable divider. Produces a strobe on q once
//   every N clk cycles (pulse mode) or a ~50% duty square wave (square mode).
//   New divisor/mode values are captured into a shadow register and only take
//   effect at a period boundary, so q never glitches mid-period.
//
//   Optional feature: define CLKDIV_SYNC_EN to add the sync_i phase-restart
//   input. Without it the phase only changes through reset or period wrap.
//
// Parameters
//   WIDTH        width of divisor and phase counter (divisor 0..2^WIDTH-1)
//   DEFAULT_DIV  active divisor after reset
//   DEFAULT_MODE active mode after reset (0 = pulse, 1 = square)
//
// Ports
//   clk          clock, all logic on posedge
//   reset_n      synchronous active-low reset
//   en           count enable; low freezes the counter and forces q/tick low
//   div_i        requested divisor N
//   mode_i       requested mode (0 pulse, 1 square)
//   load_i       one-cycle strobe capturing div_i/mode_i
//   q            divided output
//   tick         high on the first cycle of each period
//   load_pending shadow holds values not yet applied
//   sync_i       (CLKDIV_SYNC_EN only) restart the period on the next edge
module prog_clk_divider #(
    parameter int WIDTH        = 8,
    parameter int DEFAULT_DIV  = 3,
    parameter bit DEFAULT_MODE = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [WIDTH-1:0] div_i,
    input  logic             mode_i,
    input  logic             load_i,
    output logic             q,
    output logic             tick,
    output logic             load_pending
`ifdef CLKDIV_SYNC_EN
    ,
    input  logic             sync_i
`endif
);

    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_BYPASS,
        ST_RUN
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] div_a, div_a_n;
    logic             mode_a, mode_a_n;
    logic [WIDTH-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] shd_div, shd_div_n;
    logic             shd_mode, shd_mode_n;
    logic             pend_n;
    logic             sync_req;
    logic             at_wrap;
    logic             boundary;
    logic [WIDTH:0]   half;

`ifdef CLKDIV_SYNC_EN
    assign sync_req = sync_i;
`else
    assign sync_req = 1'b0;
`endif

    // Operating state is a pure decode of the active divisor.
    always_comb begin
        if (div_a == '0)
            state = ST_OFF;
        else if (div_a == WIDTH'(1))
            state = ST_BYPASS;
        else
            state = ST_RUN;
    end

    assign at_wrap  = (state == ST_RUN) && en && (cnt == div_a - 1'b1);
    // OFF/BYPASS have no phase, so every cycle is a legal switch point.
    assign boundary = (state != ST_RUN) || at_wrap || sync_req;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_a        <= DIV_RST;
            mode_a       <= DEFAULT_MODE;
            cnt          <= '0;
            shd_div      <= DIV_RST;
            shd_mode     <= DEFAULT_MODE;
            load_pending <= 1'b0;
        end else begin
            div_a        <= div_a_n;
            mode_a       <= mode_a_n;
            cnt          <= cnt_n;
            shd_div      <= shd_div_n;
            shd_mode     <= shd_mode_n;
            load_pending <= pend_n;
        end
    end

    // Next-state logic
    always_comb begin
        div_a_n    = div_a;
        mode_a_n   = mode_a;
        cnt_n      = cnt;
        shd_div_n  = shd_div;
        shd_mode_n = shd_mode;
        pend_n     = load_pending;

        if (load_i) begin
            shd_div_n  = div_i;
            shd_mode_n = mode_i;
        end

        if (boundary) begin
            // A load arriving on the boundary itself is newer than any
            // pending shadow value and is applied straight through.
            if (load_i) begin
                div_a_n  = div_i;
                mode_a_n = mode_i;
            end else if (load_pending) begin
                div_a_n  = shd_div;
                mode_a_n = shd_mode;
            end
            pend_n = 1'b0;
            cnt_n  = '0;
        end else begin
            if (load_i)
                pend_n = 1'b1;
            // Not at a boundary implies RUN; en low freezes the phase.
            if (en)
                cnt_n = cnt + 1'b1;
        end
    end

    // High-time for square mode; one extra bit so div_a=2^WIDTH-1 cannot wrap.
    assign half = ({1'b0, div_a} + 1'b1) >> 1;

    // Output logic
    always_comb begin
        q    = 1'b0;
        tick = 1'b0;
        unique case (state)
            ST_OFF: begin
                q    = 1'b0;
                tick = 1'b0;
            end
            ST_BYPASS: begin
                q    = en;
                tick = en;
            end
            default: begin
                tick = en && (cnt == '0);
                if (mode_a)
                    q = en && ({1'b0, cnt} < half);
                else
                    q = en && (cnt == '0);
            end
        endcase
    end

endmodule

// File: tb/tb_prog_clk_divider.sv
module tb_prog_clk_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         en;
    logic [W-1:0] div_i;
    logic         mode_i;
    logic         load_i;
    logic         q;
    logic         tick;
    logic         load_pending;
`ifdef CLKDIV_SYNC_EN
    logic         sync_i;
`endif

    always #5 clk = ~clk;

    prog_clk_divider #(.WIDTH(W), .DEFAULT_DIV(3), .DEFAULT_MODE(1'b0)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .en           (en),
        .div_i        (div_i),
        .mode_i       (mode_i),
        .load_i       (load_i),
        .q            (q),
        .tick         (tick),
        .load_pending (load_pending)
`ifdef CLKDIV_SYNC_EN
        ,
        .sync_i       (sync_i)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: active config, position within period, shadow config.
    int m_div, m_ph, m_sdiv;
    bit m_mode, m_smode, m_pend;

    logic last_q, last_t, last_p;

    typedef struct {
        bit en;
        bit ld;
        int div;
        bit mode;
        bit q;
        bit t;
        bit p;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Expected q: pulse = first cycle of the period, square = first ceil(N/2) cycles.
    function automatic bit exp_q(int d, bit m, int ph, bit e);
        if (d == 0) return 1'b0;
        if (d == 1) return e;
        if (!e) return 1'b0;
        if (m) return (ph < (d + 1) / 2);
        return (ph == 0);
    endfunction

    function automatic bit exp_t(int d, int ph, bit e);
        if (d == 0) return 1'b0;
        if (d == 1) return e;
        return e && (ph == 0);
    endfunction

    task automatic model_edge();
        bit sync;
        bit bnd;
        sync = 1'b0;
`ifdef CLKDIV_SYNC_EN
        sync = sync_i;
`endif
        if (!reset_n) begin
            m_div = 3; m_mode = 0; m_ph = 0;
            m_sdiv = 3; m_smode = 0; m_pend = 0;
            return;
        end
        bnd = (m_div < 2) || (en && (m_ph == m_div - 1)) || sync;
        if (bnd) begin
            if (load_i) begin
                m_div = int'(div_i); m_mode = mode_i;
            end else if (m_pend) begin
                m_div = m_sdiv; m_mode = m_smode;
            end
            m_pend = 0;
            m_ph = 0;
        end else begin
            if (load_i) m_pend = 1;
            if (en) m_ph = m_ph + 1;
        end
        if (load_i) begin
            m_sdiv = int'(div_i); m_smode = mode_i;
        end
    endtask

    task automatic check_now();
        last_q = q; last_t = tick; last_p = load_pending;
        chk("q_model",    q,            exp_q(m_div, m_mode, m_ph, en));
        chk("tick_model", tick,         exp_t(m_div, m_ph, en));
        chk("pend_model", load_pending, m_pend);
    endtask

    task automatic finish_edge();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic cyc();
        @(negedge clk);
        check_now();
        finish_edge();
    endtask

    task automatic set_in(input bit e, input bit ld, input int d, input bit m);
        en = e; load_i = ld; div_i = W'(d); mode_i = m;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        set_in(1, 0, 0, 0);
        cyc();
        reset_n = 1'b1;
    endtask

    initial begin
        int highs, first_low;
        reset_n = 1'b0;
        set_in(1, 0, 0, 0);
`ifdef CLKDIV_SYNC_EN
        sync_i = 1'b0;
`endif
        repeat (2) @(posedge clk);
        model_edge();
        #1;
        reset_n = 1'b1;

        // Default /3 pulse, then reprogramming at and away from boundaries.
        tbl[0]  = '{1, 0, 0, 0, 1, 1, 0};
        tbl[1]  = '{1, 1, 5, 1, 0, 0, 0};
        tbl[2]  = '{1, 0, 0, 0, 0, 0, 1};
        tbl[3]  = '{1, 0, 0, 0, 1, 1, 0};
        tbl[4]  = '{1, 0, 0, 0, 1, 0, 0};
        tbl[5]  = '{1, 0, 0, 0, 1, 0, 0};
        tbl[6]  = '{1, 0, 0, 0, 0, 0, 0};
        tbl[7]  = '{1, 0, 0, 0, 0, 0, 0};
        tbl[8]  = '{1, 0, 0, 0, 1, 1, 0};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 0};
        tbl[10] = '{1, 0, 0, 0, 1, 0, 0};
        tbl[11] = '{1, 1, 2, 0, 1, 0, 0};
        tbl[12] = '{1, 0, 0, 0, 0, 0, 1};
        tbl[13] = '{1, 0, 0, 0, 0, 0, 1};
        tbl[14] = '{1, 0, 0, 0, 1, 1, 0};
        tbl[15] = '{1, 1, 4, 0, 0, 0, 0};
        tbl[16] = '{1, 0, 0, 0, 1, 1, 0};
        tbl[17] = '{1, 0, 0, 0, 0, 0, 0};

        for (int i = 0; i < 18; i++) begin
            set_in(tbl[i].en, tbl[i].ld, tbl[i].div, tbl[i].mode);
            @(negedge clk);
            chk($sformatf("tbl%0d_q", i),    q,            tbl[i].q);
            chk($sformatf("tbl%0d_tick", i), tick,         tbl[i].t);
            chk($sformatf("tbl%0d_pend", i), load_pending, tbl[i].p);
            check_now();
            finish_edge();
        end

        // OFF then BYPASS.
        do_reset();
        set_in(1, 1, 0, 0); cyc();
        set_in(1, 0, 0, 0); cyc(); cyc();
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("off_q", last_q, 1'b0);
            chk("off_tick", last_t, 1'b0);
        end
        set_in(1, 1, 1, 0); cyc();
        set_in(1, 0, 0, 0); cyc();
        chk("byp_pend", last_p, 1'b0);
        chk("byp_q_en1", last_q, 1'b1);
        set_in(0, 0, 0, 0); cyc();
        chk("byp_q_en0", last_q, 1'b0);
        chk("byp_tick_en0", last_t, 1'b0);

        // /255 square: 128 high, 127 low, clean wrap.
        do_reset();
        set_in(1, 1, 255, 1); cyc();
        set_in(1, 0, 0, 0); cyc(); cyc();
        highs = 0; first_low = -1;
        for (int i = 0; i < 255; i++) begin
            cyc();
            if (last_q) highs++;
            else if (first_low < 0) first_low = i;
        end
        checks++;
        if (highs != 128) begin
            errors++;
            $display("FAIL sq255_highs: got %0d expected 128", highs);
        end
        checks++;
        if (first_low != 128) begin
            errors++;
            $display("FAIL sq255_first_low: got %0d expected 128", first_low);
        end
        cyc();
        chk("sq255_wrap_tick", last_t, 1'b1);

        // en freeze mid-period, then reset discarding a pending load.
        do_reset();
        set_in(1, 1, 5, 0); cyc();
        set_in(1, 0, 0, 0); cyc(); cyc();
        cyc(); cyc();
        set_in(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("frz_q", last_q, 1'b0);
        end
        set_in(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("resume_q", last_q, 1'b0);
        end
        cyc();
        chk("resume_wrap_q", last_q, 1'b1);
        set_in(1, 1, 7, 1); cyc();
        set_in(1, 0, 0, 0);
        reset_n = 1'b0; cyc(); reset_n = 1'b1;
        cyc();
        chk("rst_pend", last_p, 1'b0);
        chk("rst_q0", last_q, 1'b1);
        cyc(); chk("rst_q1", last_q, 1'b0);
        cyc(); chk("rst_q2", last_q, 1'b0);
        cyc(); chk("rst_q3", last_q, 1'b1);

`ifdef CLKDIV_SYNC_EN
        // Phase restart by sync_i.
        do_reset();
        set_in(1, 1, 4, 0); cyc();
        set_in(1, 0, 0, 0); cyc(); cyc();
        cyc(); cyc();
        sync_i = 1'b1; cyc(); sync_i = 1'b0;
        cyc();
        chk("sync_q", last_q, 1'b1);
        chk("sync_tick", last_t, 1'b1);
        cyc(); cyc(); cyc();
        chk("sync_q3", last_q, 1'b0);
        cyc();
        chk("sync_q4", last_q, 1'b1);
`endif

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            reset_n = ($urandom_range(0, 99) != 0);
            en      = ($urandom_range(0, 7) != 0);
            load_i  = ($urandom_range(0, 5) == 0);
            div_i   = ($urandom_range(0, 15) == 0) ? W'($urandom_range(0, 255))
                                                   : W'($urandom_range(0, 9));
            mode_i  = 1'($urandom_range(0, 1));
`ifdef CLKDIV_SYNC_EN
            sync_i  = ($urandom_range(0, 19) == 0);
`endif
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
